// File: rtl/cart_bus_arbiter.sv
// Cartridge bus sequencer: two-port arbiter driving a setup/strobe/hold access.
// Port 0 has priority; a starvation counter lets port 1 in after MAX_CONSEC wins.
module cart_bus_arbiter #(
    parameter int T_SETUP    = 1,
    parameter int T_STROBE   = 2,
    parameter int T_HOLD     = 1,
    parameter int MAX_CONSEC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        we0,
    input  logic [15:0] addr0,
    input  logic [7:0]  wdata0,
    output logic        ack0,
    output logic [7:0]  rdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [15:0] addr1,
    input  logic [7:0]  wdata1,
    output logic        ack1,
    output logic [7:0]  rdata1,
    output logic        busy,
    output logic        grant,
    output logic [15:0] cart_a,
    output logic [7:0]  cart_dout,
    output logic        cart_dout_en,
    input  logic [7:0]  cart_din,
    output logic        cart_rd,
    output logic        cart_wr,
    output logic        cart_cs
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] SETUP_LAST  = 4'(T_SETUP - 1);
    localparam logic [3:0] STROBE_LAST = 4'(T_STROBE - 1);
    localparam logic [3:0] HOLD_LAST   = 4'(T_HOLD - 1);
    localparam logic [3:0] MAX_CNT     = 4'(MAX_CONSEC);

    state_t      state, state_n;
    logic [3:0]  phase, phase_n;
    logic [3:0]  starve_cnt, starve_n;
    logic        grant_n;
    logic        pick1;
    logic        lat_we, lat_we_n;
    logic [15:0] lat_a, lat_a_n;
    logic [7:0]  lat_d, lat_d_n;
    logic        active_n;
    logic        last_hold_n;
    logic        cs_n;
    logic        wr_txn_n;

    // Next-state, arbitration and request latching.
    always_comb begin
        state_n  = state;
        phase_n  = phase + 4'd1;
        starve_n = starve_cnt;
        grant_n  = grant;
        lat_we_n = lat_we;
        lat_a_n  = lat_a;
        lat_d_n  = lat_d;
        pick1    = 1'b0;
        unique case (state)
            IDLE: begin
                phase_n = 4'd0;
                if (req0 || req1) begin
                    pick1    = req1 && (!req0 || starve_cnt == MAX_CNT);
                    grant_n  = pick1;
                    lat_we_n = pick1 ? we1 : we0;
                    lat_a_n  = pick1 ? addr1 : addr0;
                    lat_d_n  = pick1 ? wdata1 : wdata0;
                    state_n  = SETUP;
                    if (pick1 || !req1) begin
                        starve_n = 4'd0;
                    end else if (starve_cnt < MAX_CNT) begin
                        starve_n = starve_cnt + 4'd1;
                    end
                end
            end
            SETUP: begin
                if (phase == SETUP_LAST) begin
                    state_n = STROBE;
                    phase_n = 4'd0;
                end
            end
            STROBE: begin
                if (phase == STROBE_LAST) begin
                    state_n = HOLD;
                    phase_n = 4'd0;
                end
            end
            HOLD: begin
                if (phase == HOLD_LAST) begin
                    state_n = IDLE;
                    phase_n = 4'd0;
                end
            end
            default: begin
                state_n = IDLE;
                phase_n = 4'd0;
            end
        endcase
    end

    // Bus pin values for the cycle that follows the next edge.
    always_comb begin
        active_n    = state_n != IDLE;
        last_hold_n = state_n == HOLD && phase_n == HOLD_LAST;
        cs_n        = active_n && lat_a_n >= 16'hA000
                      && lat_a_n <= 16'hFDFF;
        wr_txn_n    = active_n && lat_we_n;
    end

    // Sequencer state and latched request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= 4'd0;
            starve_cnt <= 4'd0;
            grant      <= 1'b0;
            lat_we     <= 1'b0;
            lat_a      <= 16'd0;
            lat_d      <= 8'd0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            starve_cnt <= starve_n;
            grant      <= grant_n;
            lat_we     <= lat_we_n;
            lat_a      <= lat_a_n;
            lat_d      <= lat_d_n;
        end
    end

    // Registered bus outputs and completion pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy         <= 1'b0;
            cart_a       <= 16'd0;
            cart_cs      <= 1'b0;
            cart_rd      <= 1'b0;
            cart_wr      <= 1'b0;
            cart_dout_en <= 1'b0;
            cart_dout    <= 8'd0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
        end else begin
            busy         <= active_n;
            cart_a       <= active_n ? lat_a_n : 16'd0;
            cart_cs      <= cs_n;
            cart_rd      <= !lat_we_n
                            && (state_n == SETUP || state_n == STROBE);
            cart_wr      <= lat_we_n && state_n == STROBE;
            cart_dout_en <= wr_txn_n;
            cart_dout    <= wr_txn_n ? lat_d_n : 8'd0;
            ack0         <= last_hold_n && !grant_n;
            ack1         <= last_hold_n && grant_n;
        end
    end

    // Read data is captured at the close of the final strobe cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0 <= 8'd0;
            rdata1 <= 8'd0;
        end else if (state == STROBE && phase == STROBE_LAST && !lat_we) begin
            if (grant) begin
                rdata1 <= cart_din;
            end else begin
                rdata0 <= cart_din;
            end
        end
    end

endmodule

// File: tb/tb_cart_bus_arbiter.sv
// Scoreboard bench for cart_bus_arbiter: random two-port traffic,
// transaction-level reference model, bus observer, directed reset/starvation runs.
module tb_cart_bus_arbiter;

    localparam int TS   = 1;
    localparam int TST  = 2;
    localparam int TH   = 1;
    localparam int MAXC = 4;
    localparam int TOT  = TS + TST + TH;

    logic        clk, rst;
    logic        req0, we0, ack0, req1, we1, ack1;
    logic [15:0] addr0, addr1, cart_a;
    logic [7:0]  wdata0, wdata1, rdata0, rdata1, cart_dout, cart_din;
    logic        busy, grant, cart_dout_en, cart_rd, cart_wr, cart_cs;

    cart_bus_arbiter #(
        .T_SETUP(TS), .T_STROBE(TST), .T_HOLD(TH), .MAX_CONSEC(MAXC)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1),
        .busy(busy), .grant(grant),
        .cart_a(cart_a), .cart_dout(cart_dout), .cart_dout_en(cart_dout_en),
        .cart_din(cart_din), .cart_rd(cart_rd), .cart_wr(cart_wr),
        .cart_cs(cart_cs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] memf(logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Memory model: data depends on address and on how long rd has been held,
    // so only a capture at the end of the strobe returns the expected byte.
    int rd_run;
    always @(negedge clk) begin
        if (rst) rd_run = 0;
        else rd_run = cart_rd ? rd_run + 1 : 0;
        cart_din = memf(cart_a) + 8'(rd_run);
    end

    typedef struct {
        int          port;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          ack_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t me, ce;
    int   cyc, next_arb, consec;
    bit   w1;

    // Reference model: one arbitration per free edge, fixed-length access.
    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
            cyc = 0;
            next_arb = 0;
            consec = 0;
        end else begin
            cyc++;
            if (cyc >= next_arb && (req0 || req1)) begin
                w1 = req1 && (!req0 || consec == MAXC);
                me.port  = w1 ? 1 : 0;
                me.we    = w1 ? we1 : we0;
                me.addr  = w1 ? addr1 : addr0;
                me.wdata = w1 ? wdata1 : wdata0;
                me.ack_cyc = cyc + TOT - 1;
                sb.push_back(me);
                next_arb = cyc + TOT + 1;
                if (w1 || !req1) consec = 0;
                else if (consec < MAXC) consec++;
            end
        end
    end

    int ob_n, ob_rd, ob_wr, ob_wfirst, ob_en, ob_cs;
    logic [15:0] ob_a;
    logic [7:0]  ob_d;
    bit ob_abad, ob_dbad;
    int obs_ports[$];

    task automatic ob_clear();
        ob_n = 0; ob_rd = 0; ob_wr = 0; ob_wfirst = 0;
        ob_en = 0; ob_cs = 0; ob_abad = 0; ob_dbad = 0;
        ob_a = '0; ob_d = '0;
    endtask

    // Bus observer and scoreboard checker.
    always @(negedge clk) begin
        if (rst) begin
            ob_clear();
        end else begin
            if (cart_rd && cart_wr) check("rd_wr_overlap", 1, 0);
            if (!busy && (cart_rd || cart_wr || cart_cs || cart_dout_en))
                check("idle_bus_quiet", 1, 0);
            if (busy) begin
                ob_n++;
                if (ob_n == 1) ob_a = cart_a;
                else if (cart_a != ob_a) ob_abad = 1;
                if (cart_rd) ob_rd++;
                if (cart_wr) begin
                    if (ob_wr == 0) ob_wfirst = ob_n;
                    ob_wr++;
                end
                if (cart_dout_en) begin
                    if (ob_en == 0) ob_d = cart_dout;
                    else if (cart_dout != ob_d) ob_dbad = 1;
                    ob_en++;
                end
                if (cart_cs) ob_cs++;
            end
            if (ack0 || ack1) begin
                if (sb.size() == 0) begin
                    check("spurious_ack", 1, 0);
                end else begin
                    ce = sb.pop_front();
                    obs_ports.push_back(ack1 ? 1 : 0);
                    check("ack_port", ack1 ? 1 : 0, ce.port);
                    check("ack_both", ack0 && ack1, 0);
                    check("ack_cycle", cyc, ce.ack_cyc);
                    check("grant", grant, ce.port);
                    check("txn_len", ob_n, TOT);
                    check("addr", ob_a, ce.addr);
                    check("addr_stable", ob_abad, 0);
                    check("rd_cycles", ob_rd, ce.we ? 0 : TS + TST);
                    check("wr_cycles", ob_wr, ce.we ? TST : 0);
                    check("en_cycles", ob_en, ce.we ? TOT : 0);
                    check("cs_cycles", ob_cs,
                          (ce.addr >= 16'hA000 && ce.addr <= 16'hFDFF) ? TOT : 0);
                    if (ce.we) begin
                        check("wr_start", ob_wfirst, TS + 1);
                        check("dout", ob_d, ce.wdata);
                        check("dout_stable", ob_dbad, 0);
                    end else begin
                        check("rdata", ce.port == 1 ? rdata1 : rdata0,
                              memf(ce.addr) + 8'(TS + TST));
                    end
                end
                ob_clear();
            end
        end
    end

    task automatic set_port(int p, logic r, logic we, logic [15:0] a,
                            logic [7:0] d);
        if (p == 0) begin
            req0 = r; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = we; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic do_txn(int p, logic we, logic [15:0] a, logic [7:0] d);
        bit got = 0;
        set_port(p, 1'b1, we, a, d);
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = (p == 0) ? ack0 : ack1;
        end
        check("ack_seen", got, 1);
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 5))
            0: return 16'h0150;
            1: return 16'hA000;
            2: return 16'h9FFF;
            3: return 16'hFDFF;
            4: return 16'hFE00;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic rand_port(int p, int n, int maxgap);
        int gap;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(0, maxgap);
            if (gap > 0) begin
                if (p == 0) req0 = 1'b0;
                else req1 = 1'b0;
                repeat (gap) @(negedge clk);
            end
            do_txn(p, 1'($urandom), pick_addr(), 8'($urandom));
        end
        if (p == 0) req0 = 1'b0;
        else req1 = 1'b0;
    endtask

    int pat[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    bit seen;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_port(0, 1'b0, 1'b0, 16'd0, 8'd0);
        set_port(1, 1'b0, 1'b0, 16'd0, 8'd0);
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_ack0", ack0, 0);
        check("rst_ack1", ack1, 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_rdata1", rdata1, 0);
        check("rst_cart_a", cart_a, 0);
        check("rst_dout", cart_dout, 0);
        check("rst_dout_en", cart_dout_en, 0);
        check("rst_rd", cart_rd, 0);
        check("rst_wr", cart_wr, 0);
        check("rst_cs", cart_cs, 0);
        rst = 1'b0;

        fork
            rand_port(0, 25, 6);
            rand_port(1, 25, 6);
        join
        repeat (8) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        do_txn(0, 1'b0, 16'h0150, 8'h00);
        req0 = 1'b0;
        repeat (2) @(negedge clk);

        set_port(1, 1'b1, 1'b1, 16'hA000, 8'hA5);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = cart_wr;
        end
        check("wr_strobe_seen", seen, 1);
        #2;
        rst = 1'b1;
        req1 = 1'b0;
        #1;
        check("arst_wr", cart_wr, 0);
        check("arst_cs", cart_cs, 0);
        check("arst_dout_en", cart_dout_en, 0);
        check("arst_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_no_ack", ack0 || ack1, 0);
        end
        rst = 1'b0;
        do_txn(1, 1'b1, 16'hA000, 8'hA5);
        req1 = 1'b0;

        repeat (4) @(negedge clk);
        obs_ports.delete();
        fork
            rand_port(0, 8, 0);
            rand_port(1, 2, 0);
        join
        repeat (8) @(negedge clk);
        check("starve_len", obs_ports.size(), 10);
        for (int i = 0; i < 10 && i < obs_ports.size(); i++)
            check("starve_seq", obs_ports[i], pat[i]);
        check("sb_empty_end", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
